// File: rtl/decoder38_seq.sv
// rtl/decoder38_seq.sv - registered 3-to-8 decoder sequencer with valid/ready input and one-entry pending buffer
// Each accepted code drives its one-hot word for HOLD enabled cycles; e (active-low) pauses everything.
module decoder38_seq #(
  parameter int HOLD = 4,
  parameter int CW   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       e,
  input  logic       code_valid,
  output logic       code_ready,
  input  logic [2:0] code,
  output logic [7:0] w,
  output logic       w_valid,
  output logic       busy
);

  typedef enum logic {IDLE, DRIVE} state_t;

  localparam int HOLD_EFF = (HOLD < 1) ? 1 : HOLD;
  localparam logic [CW-1:0] LOAD = CW'(HOLD_EFF - 1);

  state_t          state_q, state_d;
  logic [2:0]      act_code_q, act_code_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      pend_code_q, pend_code_d;
  logic            pend_full_q, pend_full_d;
  logic [7:0]      w_q, w_d;
  logic            w_valid_q, w_valid_d;
  logic            busy_q, busy_d;
  logic            xfer;

  assign code_ready = ~e & ~pend_full_q;
  assign xfer       = code_valid & code_ready;

  always_comb begin
    state_d     = state_q;
    act_code_d  = act_code_q;
    cnt_d       = cnt_q;
    pend_code_d = pend_code_q;
    pend_full_d = pend_full_q;

    if (!e) begin
      case (state_q)
        IDLE: begin
          if (xfer) begin
            act_code_d = code;
            cnt_d      = LOAD;
            state_d    = DRIVE;
          end
        end
        DRIVE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            if (xfer) begin
              pend_code_d = code;
              pend_full_d = 1'b1;
            end
          end else if (pend_full_q) begin
            // xfer is impossible here: code_ready is low while pending is full
            act_code_d  = pend_code_q;
            cnt_d       = LOAD;
            pend_full_d = 1'b0;
          end else if (xfer) begin
            act_code_d = code;
            cnt_d      = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    w_valid_d = (state_d == DRIVE);
    w_d       = w_valid_d ? (8'd1 << act_code_d) : 8'h00;
    busy_d    = (state_d == DRIVE) | pend_full_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      act_code_q  <= '0;
      cnt_q       <= '0;
      pend_code_q <= '0;
      pend_full_q <= 1'b0;
      w_q         <= 8'h00;
      w_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_code_q  <= act_code_d;
      cnt_q       <= cnt_d;
      pend_code_q <= pend_code_d;
      pend_full_q <= pend_full_d;
      w_q         <= w_d;
      w_valid_q   <= w_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Pause blanks the registered word without disturbing it, so it resumes intact.
  assign w       = w_q & {8{~e}};
  assign w_valid = w_valid_q & ~e;
  assign busy    = busy_q;

endmodule

// File: tb/tb_decoder38_seq.sv
// tb/tb_decoder38_seq.sv - scoreboard bench for decoder38_seq
// Driver pushes HOLD expected words per accepted code; monitor pops on every valid output cycle.
module tb_decoder38_seq;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       e;
  logic       code_valid;
  logic       code_ready;
  logic [2:0] code;
  logic [7:0] w;
  logic       w_valid;
  logic       busy;

  int vec  = 0;
  int errs = 0;
  logic [7:0] exp_q[$];

  decoder38_seq #(.HOLD(H), .CW(8)) dut (
    .clk(clk), .rst(rst), .e(e),
    .code_valid(code_valid), .code_ready(code_ready), .code(code),
    .w(w), .w_valid(w_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vec++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: one sample per cycle, just after the rising edge.
  always @(posedge clk) begin
    #1;
    if (w_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        vec++;
        errs++;
        $display("FAIL unexpected_word: got %0h expected none at %0t", w, $time);
      end else begin
        chk("w_stream", w, exp_q.pop_front());
      end
    end else begin
      chk("w_idle_zero", w, 8'h00);
      if (exp_q.size() != 0 && e === 1'b0 && rst === 1'b0)
        chk("no_gap_valid", w_valid, 1'b1);
    end
  end

  // Called just after a falling edge; returns just after the falling edge following the transfer.
  task automatic send(input logic [2:0] c);
    int t = 0;
    code       = c;
    code_valid = 1'b1;
    while (code_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      chk("send_timeout", 0, 1);
    end else begin
      for (int i = 0; i < H; i++) exp_q.push_back(8'd1 << c);
      @(negedge clk);
    end
    code_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    errs++;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    rst = 1'b1; e = 1'b0; code_valid = 1'b1; code = 3'd5;
    repeat (3) @(negedge clk);
    chk("rst_w", w, 8'h00);
    chk("rst_w_valid", w_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    code_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", code_ready, 1'b1);

    // Single code 5: four cycles of 8'h20, then idle with busy low
    send(3'd5);
    for (int i = 0; i < H; i++) begin
      chk("single_w", w, 8'h20);
      chk("single_busy", busy, 1'b1);
      @(negedge clk);
    end
    chk("single_end_w", w, 8'h00);
    chk("single_end_valid", w_valid, 1'b0);
    chk("single_end_busy", busy, 1'b0);
    drain();

    // Streaming 0,7,3 back to back
    send(3'd0);
    send(3'd7);
    chk("stream_ready_full", code_ready, 1'b0);
    chk("stream_busy", busy, 1'b1);
    send(3'd3);
    drain();

    // Pause after the second hold cycle of code 2
    send(3'd2);
    chk("pause_pre_w", w, 8'h04);
    @(negedge clk);
    e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("pause_w", w, 8'h00);
      chk("pause_ready", code_ready, 1'b0);
      chk("pause_busy", busy, 1'b1);
      @(negedge clk);
    end
    e = 1'b0;
    #1 chk("resume_w", w, 8'h04);
    drain();

    // Code 6 offered in the final hold cycle of code 1
    send(3'd1);
    repeat (H - 1) @(negedge clk);
    chk("last_cycle_w", w, 8'h02);
    send(3'd6);
    chk("last_cycle_next_w", w, 8'h40);
    drain();

    // Reset with code 4 active and code 1 pending
    send(3'd4);
    send(3'd1);
    chk("midop_busy", busy, 1'b1);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midop_rst_w", w, 8'h00);
    chk("midop_rst_valid", w_valid, 1'b0);
    chk("midop_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_ready", code_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/decoder38_seq.md
# decoder38_seq

Registered 3-to-8 decoder sequencer: accepts 3-bit codes over a valid/ready handshake and drives the matching one-hot word on `w` for `HOLD` consecutive cycles each, back-to-back with no gap cycles. It is the inverse companion of the team's 8-to-3 encoder and uses the same active-low enable `e`. It buffers one pending code so an upstream producer can stream codes without bubbles. Typical use: scanning one-hot select lines (LED/row strobes, mux selects) from a compact code stream.

## Interface

- `HOLD`, 4: cycles each one-hot word is driven; legal 1..255 (0 is treated as 1).
- `CW`, 8: hold-counter width; must satisfy `HOLD` < 2^`CW`.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `e`  in  1  enable, active-low; `e`=1 pauses the block.
- `code_valid`  in  1  `code` is presented.
- `code_ready`  out  1  block can accept a code this cycle.
- `code`  in  3  code to decode, 0..7.
- `w`  out  8  registered one-hot output, 8'h00 when idle or paused.
- `w_valid`  out  1  registered; high while a code is being driven.
- `busy`  out  1  registered; high while a code is active or pending.

## Operation

- Storage: active register (code plus hold counter) and a single-entry pending register (code plus full flag).
- FSM states: IDLE (no active code) and DRIVE (active code, counter running).
- Handshake: transfer occurs on a rising edge where `code_valid`=1 and `code_ready`=1. `code_ready` = ~`e` & ~pending_full (combinational). `code` must be held stable while `code_valid`=1 and `code_ready`=0.
- IDLE + transfer: code goes directly to the active register, counter := `HOLD`-1, state -> DRIVE.
- DRIVE, counter > 0: counter decrements each enabled cycle; a transfer fills pending.
- DRIVE, counter = 0 (last hold cycle):
  - If pending is full: pending moves to active, counter := `HOLD`-1, stay in DRIVE, and pending is freed.
  - Else, if a transfer occurs in this same cycle: the new code goes directly to active.
  - Else: state -> IDLE.
- Simultaneous accept into pending and pending -> active cannot happen, because `code_ready` is 0 while pending is full.
- Output: `w` = 1 << active_code in DRIVE, 8'h00 in IDLE. `w_valid` = (state == DRIVE). `busy` = DRIVE | pending_full.
- Pause (`e`=1): `w` is forced to 8'h00 and `w_valid` to 0. Counter, state and pending are frozen, and no transfers occur. On `e`=0 the active code resumes with its remaining count.
- Code 0 decodes to `w`=8'h01; code 7 decodes to `w`=8'h80.

## Timing

- Reset (asynchronous, immediate): `w`=8'h00, `w_valid`=0, `busy`=0, state IDLE, pending empty, counter 0. `code_ready`=1 if `e`=0.
- Latency: a code accepted at edge N appears on `w` and `w_valid` after edge N. It is held through edge N+`HOLD`, giving exactly `HOLD` enabled cycles.
- Streaming: with continuous valid codes, `w` changes directly from one one-hot value to the next with zero idle cycles. Throughput is one code per `HOLD` cycles.
- `HOLD`=1: a code is accepted every cycle; pending never stays full beyond one cycle.
- Pause: each cycle with `e`=1 extends the current word's lifetime by one cycle. `w` reads 0 during the pause.
- Reset mid-operation discards both active and pending codes. `w` goes to 0 asynchronously.

## Test plan

- Reset/idle: assert `rst` with `code_valid`=1 -> `w`=00, `w_valid`=0, `busy`=0. After release with `e`=0 -> `code_ready`=1.
- Single code: `HOLD`=4, send code 5 at edge 10 -> `w`=8'h20 and `w_valid`=1 for cycles 11-14, 8'h00 from cycle 15, `busy` drops after edge 14.
- Streaming: send codes 0,7,3 back-to-back with valid held -> `w` reads 01 x4, 80 x4, 08 x4 with no gap. `code_ready` is low while pending is full.
- Pause: code 2 with `HOLD`=4, `e`=1 for 3 cycles after the 2nd hold cycle -> `w` reads 04,04,00,00,00,04,04. `code_ready`=0 during the pause.
- Last-cycle accept: pending empty, new code 6 offered in the final hold cycle of code 1 -> `w` goes 02 -> 40 with no idle cycle.
- Reset mid-op: active code 4 plus pending code 1, pulse `rst` -> `w`=00 immediately, and code 1 is never driven.
